// File: rtl/sysid_ctrl_pkg.sv
// Shared types and default constants for the system-ID check controller.
// Holds the FSM state encoding, result flag bundle and counter sizing helper.
package sysid_ctrl_pkg;

  localparam logic [31:0] DEFAULT_EXPECTED_ID  = 32'd49153;
  localparam logic [31:0] DEFAULT_EXPECTED_TS  = 32'd1531293970;
  localparam int unsigned DEFAULT_WAIT_TIMEOUT = 255;
  localparam int unsigned DEFAULT_MAX_RETRY    = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_RETRY = 3'd4
  } state_e;

  typedef struct packed {
    logic id_ok;
    logic ts_ok;
    logic match;
    logic timeout_err;
  } result_t;

  // Width of a counter that must hold values 0..max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sysid_check_ctrl.sv
// Reads the sysid slave (ID word, then optional build timestamp), compares
// against the expected build values and reports match / mismatch / timeout.
module sysid_check_ctrl
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS  = DEFAULT_EXPECTED_TS,
  parameter bit          CHECK_TS     = 1'b1,
  parameter int unsigned WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT,
  parameter int unsigned MAX_RETRY    = DEFAULT_MAX_RETRY
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic        avm_address_o,
  output logic        avm_read_o,
  input  logic [31:0] avm_readdata_i,
  input  logic        avm_waitrequest_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        id_ok_o,
  output logic        ts_ok_o,
  output logic        match_o,
  output logic        timeout_err_o,
  output logic [31:0] id_value_o,
  output logic [31:0] ts_value_o
);

  localparam int unsigned WAIT_W = cnt_width(WAIT_TIMEOUT);
  localparam int unsigned ATT_W  = cnt_width(MAX_RETRY);

  // Last count value before the abort fires; the read stays up WAIT_TIMEOUT cycles.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);
  localparam logic [ATT_W-1:0]  ATT_LAST  = ATT_W'(MAX_RETRY - 1);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic              tmo_q, tmo_d;
  logic              done_q, done_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ATT_W-1:0]  attempt_q, attempt_d;
  logic [31:0]       id_value_q, id_value_d;
  logic [31:0]       ts_value_q, ts_value_d;
  result_t           result_q, result_d;
  logic              accept;

  assign avm_read_o    = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
  assign avm_address_o = (state_q == ST_RD_TS);
  assign busy_o        = (state_q != ST_IDLE);
  assign accept        = avm_read_o && !avm_waitrequest_i;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path infers a latch.
    state_d    = state_q;
    pending_d  = pending_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    wait_cnt_d = wait_cnt_q;
    attempt_d  = attempt_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    result_d   = result_q;

    unique case (state_q)
      ST_IDLE: begin
        // A start arriving alongside the done pulse is deliberately dropped.
        if ((pending_q || start_i) && !done_q) begin
          state_d   = ST_RD_ID;
          pending_d = 1'b0;
        end
      end

      ST_RD_ID, ST_RD_TS: begin
        if (accept) begin
          wait_cnt_d = '0;
          if (state_q == ST_RD_ID) begin
            id_value_d = avm_readdata_i;
            state_d    = CHECK_TS ? ST_RD_TS : ST_CHECK;
          end else begin
            ts_value_d = avm_readdata_i;
            state_d    = ST_CHECK;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = ST_RETRY;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_RETRY: begin
        attempt_d = attempt_q + ATT_W'(1);
        if (attempt_q == ATT_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_RD_ID;
        end
      end

      ST_CHECK: begin
        result_d.id_ok       = (id_value_q == EXPECTED_ID) && !tmo_q;
        result_d.ts_ok       = (!CHECK_TS || (ts_value_q == EXPECTED_TS)) && !tmo_q;
        result_d.match       = result_d.id_ok && result_d.ts_ok;
        result_d.timeout_err = tmo_q;
        done_d               = 1'b1;
        attempt_d            = '0;
        tmo_d                = 1'b0;
        state_d              = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b1;
      tmo_q      <= 1'b0;
      done_q     <= 1'b0;
      wait_cnt_q <= '0;
      attempt_q  <= '0;
      id_value_q <= '0;
      ts_value_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      wait_cnt_q <= wait_cnt_d;
      attempt_q  <= attempt_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      result_q   <= result_d;
    end
  end

  assign done_o        = done_q;
  assign id_ok_o       = result_q.id_ok;
  assign ts_ok_o       = result_q.ts_ok;
  assign match_o       = result_q.match;
  assign timeout_err_o = result_q.timeout_err;
  assign id_value_o    = id_value_q;
  assign ts_value_o    = ts_value_q;

endmodule
